// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory controller among NUM_CORES core ports.
// Latency: grant is combinational; memory strobes 1 edge after grant; read data READ_LATENCY+1 edges after grant.
// Backpressure: a core holds its request until granted; losing cores simply wait, nothing is queued.

module mem_arbiter #(
  parameter int NUM_CORES    = 2,
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_SIZE     = 256,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0,
  localparam int ADDR_W      = $clog2(MEM_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]    core_addr,
  input  logic [NUM_CORES*MEM_WIDTH-1:0] core_wdata,
  output logic [NUM_CORES-1:0]           core_grant,
  output logic [NUM_CORES-1:0]           core_rvalid,
  output logic [MEM_WIDTH-1:0]           core_rdata,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_write_en,
  output logic                           mem_read_en,
  output logic [MEM_WIDTH-1:0]           mem_write_val,
  input  logic [MEM_WIDTH-1:0]           mem_read_val
);

  // Width of a core index; a single core still needs one bit to carry its index.
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // One entry of the read-return pipeline: which core issued the read, if any.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Round-robin pointer: the core with the highest priority this cycle.
  logic [IDX_W-1:0]     r_ptr;

  // Registered memory port.
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [MEM_WIDTH-1:0] r_mem_wval;
  logic                 r_mem_we;
  logic                 r_mem_re;

  // Read tags travel alongside the memory's own read latency.
  tag_t                 r_tag [READ_LATENCY];

  // Registered read return.
  logic [NUM_CORES-1:0] r_rvalid;
  logic [MEM_WIDTH-1:0] r_rdata;

  // Arbitration results.
  logic                 w_gnt_vld;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic [IDX_W-1:0]     w_cand;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_ptr_nxt;

  // Per-core fields unpacked from the flat buses, and the winner's selection.
  logic [ADDR_W-1:0]    w_addr_arr  [NUM_CORES];
  logic [MEM_WIDTH-1:0] w_wdata_arr [NUM_CORES];
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [MEM_WIDTH-1:0] w_sel_wdata;
  logic                 w_sel_we;

  // Split the packed per-core buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_addr_arr[i]  = core_addr[i*ADDR_W +: ADDR_W];
      w_wdata_arr[i] = core_wdata[i*MEM_WIDTH +: MEM_WIDTH];
    end
  end

  // Scan candidates in priority order and take the first requester.
  // Fixed priority scans from index 0; round-robin starts at the pointer and wraps.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_sum     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (ARB_MODE == 1) begin
        w_sum = (IDX_W+1)'(i);
      end else begin
        w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
        if (w_sum >= (IDX_W+1)'(NUM_CORES)) begin
          w_sum = w_sum - (IDX_W+1)'(NUM_CORES);
        end
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_gnt_vld && core_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Winner's access fields and the pointer value that follows a grant.
  always_comb begin
    w_sel_addr  = w_addr_arr[w_gnt_idx];
    w_sel_wdata = w_wdata_arr[w_gnt_idx];
    w_sel_we    = core_we[w_gnt_idx];
    w_ptr_nxt   = (w_gnt_idx == IDX_W'(NUM_CORES-1)) ? '0 : w_gnt_idx + IDX_W'(1);
  end

  assign core_grant = w_gnt_vld ? (NUM_CORES'(1) << w_gnt_idx) : '0;

  // Advance the round-robin pointer past the winner; fixed priority leaves it at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if ((ARB_MODE == 0) && w_gnt_vld) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Register the winning access onto the memory port; strobes last exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_mem_wval <= '0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
    end else if (w_gnt_vld) begin
      r_mem_addr <= w_sel_addr;
      r_mem_wval <= w_sel_wdata;
      r_mem_we   <= w_sel_we;
      r_mem_re   <= ~w_sel_we;
    end else begin
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
    end
  end

  // Shift a tag per cycle: valid with the core index for a read, invalid otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{vld: w_gnt_vld & ~w_sel_we, idx: w_gnt_idx};
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Deliver memory data to the issuing core when its tag emerges; data holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_tag[READ_LATENCY-1].vld) begin
        r_rvalid <= NUM_CORES'(1) << r_tag[READ_LATENCY-1].idx;
        r_rdata  <= mem_read_val;
      end
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_write_val = r_mem_wval;
  assign mem_write_en  = r_mem_we;
  assign mem_read_en   = r_mem_re;
  assign core_rvalid   = r_rvalid;
  assign core_rdata    = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter configurations checked against a cycle-level behavioural model.
// Latency: model predicts grant in-cycle, memory strobes one edge later, read data RL+1 edges later.
// Backpressure: directed stimulus holds requests until granted.

module tb_mem_arbiter;

  localparam int NI = 3;
  // Instance 0: 3 cores RR RL1; instance 1: 2 cores fixed RL1; instance 2: 4 cores RR RL3.
  localparam int P_N    [NI] = '{3, 2, 4};
  localparam int P_MODE [NI] = '{0, 1, 0};
  localparam int P_RL   [NI] = '{1, 1, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req   [NI];
  logic [3:0]   we    [NI];
  logic [31:0]  addr  [NI];
  logic [127:0] wdata [NI];

  logic [2:0]  grant_a, rvalid_a;
  logic [1:0]  grant_b, rvalid_b;
  logic [3:0]  grant_c, rvalid_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [31:0] mwv_a, mwv_b, mwv_c;
  logic [31:0] mrv_a, mrv_b, mrv_c;
  logic [7:0]  maddr_a, maddr_b, maddr_c;
  logic        mwe_a, mwe_b, mwe_c, mre_a, mre_b, mre_c;

  mem_arbiter #(.NUM_CORES(3), .MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(1), .ARB_MODE(0)) u_a (
    .clk(clk), .reset(reset), .core_req(req[0][2:0]), .core_we(we[0][2:0]),
    .core_addr(addr[0][23:0]), .core_wdata(wdata[0][95:0]), .core_grant(grant_a),
    .core_rvalid(rvalid_a), .core_rdata(rdata_a), .mem_addr(maddr_a), .mem_write_en(mwe_a),
    .mem_read_en(mre_a), .mem_write_val(mwv_a), .mem_read_val(mrv_a));

  mem_arbiter #(.NUM_CORES(2), .MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(1), .ARB_MODE(1)) u_b (
    .clk(clk), .reset(reset), .core_req(req[1][1:0]), .core_we(we[1][1:0]),
    .core_addr(addr[1][15:0]), .core_wdata(wdata[1][63:0]), .core_grant(grant_b),
    .core_rvalid(rvalid_b), .core_rdata(rdata_b), .mem_addr(maddr_b), .mem_write_en(mwe_b),
    .mem_read_en(mre_b), .mem_write_val(mwv_b), .mem_read_val(mrv_b));

  mem_arbiter #(.NUM_CORES(4), .MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(3), .ARB_MODE(0)) u_c (
    .clk(clk), .reset(reset), .core_req(req[2]), .core_we(we[2]),
    .core_addr(addr[2]), .core_wdata(wdata[2]), .core_grant(grant_c),
    .core_rvalid(rvalid_c), .core_rdata(rdata_c), .mem_addr(maddr_c), .mem_write_en(mwe_c),
    .mem_read_en(mre_c), .mem_write_val(mwv_c), .mem_read_val(mrv_c));

  // Memory controllers: RL=1 reads combinationally, RL=3 delays the address by two cycles.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_c [256];
  logic [7:0]  ah1, ah2;

  always @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 256; i++) mem_a[i] <= '0;
    else if (mwe_a) mem_a[maddr_a] <= mwv_a;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    else if (mwe_b) mem_b[maddr_b] <= mwv_b;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_c[i] <= '0;
      ah1 <= '0;
      ah2 <= '0;
    end else begin
      if (mwe_c) mem_c[maddr_c] <= mwv_c;
      ah1 <= maddr_c;
      ah2 <= ah1;
    end
  end
  assign mrv_a = mem_a[maddr_a];
  assign mrv_b = mem_b[maddr_b];
  assign mrv_c = mem_c[ah2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: expected registered outputs after the next edge, pointer, memory, scheduled returns.
  int          m_ptr [NI];
  logic [31:0] e_rd  [NI];
  logic [31:0] e_wv  [NI];
  logic [7:0]  e_ma  [NI];
  logic        e_we  [NI];
  logic        e_re  [NI];
  logic [31:0] m_mem [NI][256];
  logic        due_v [NI][8];
  int          due_c [NI][8];
  logic [31:0] due_d [NI][8];
  int          cyc = 0;

  function automatic int arbitrate(input int k);
    int c;
    for (int i = 0; i < P_N[k]; i++) begin
      c = (P_MODE[k] == 1) ? i : (m_ptr[k] + i) % P_N[k];
      if (((req[k] >> c) & 4'b1) != 4'b0) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle(input int k, input logic [3:0] g, input logic [3:0] rv,
                             input logic [31:0] rd, input logic [7:0] ma, input logic mwe,
                             input logic mre, input logic [31:0] mwv);
    int w;
    int slot;
    int s2;
    logic [3:0] eg;
    logic [3:0] erv;
    string t;
    t = $sformatf("dut%0d cyc%0d", k, cyc);
    slot = cyc % 8;
    if (reset) begin
      m_ptr[k] = 0;
      e_rd[k] = '0; e_wv[k] = '0; e_ma[k] = '0; e_we[k] = 1'b0; e_re[k] = 1'b0;
      for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
      for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
      erv = '0;
    end else begin
      erv = '0;
      if (due_v[k][slot]) begin
        erv = 4'b1 << due_c[k][slot];
        e_rd[k] = due_d[k][slot];
        due_v[k][slot] = 1'b0;
      end
    end
    chk({t, " rvalid"}, 32'(rv), 32'(erv));
    chk({t, " rdata"}, rd, e_rd[k]);
    chk({t, " mem_addr"}, 32'(ma), 32'(e_ma[k]));
    chk({t, " mem_write_en"}, 32'(mwe), 32'(e_we[k]));
    chk({t, " mem_read_en"}, 32'(mre), 32'(e_re[k]));
    chk({t, " mem_write_val"}, mwv, e_wv[k]);
    w = arbitrate(k);
    eg = (w < 0) ? 4'b0 : (4'b1 << w);
    chk({t, " grant"}, 32'(g), 32'(eg));
    if (!reset) begin
      if (w >= 0) begin
        e_ma[k] = 8'(addr[k] >> (w * 8));
        e_wv[k] = 32'(wdata[k] >> (w * 32));
        e_we[k] = ((we[k] >> w) & 4'b1) != 4'b0;
        e_re[k] = !e_we[k];
        if (e_we[k]) begin
          m_mem[k][e_ma[k]] = e_wv[k];
        end else begin
          s2 = (cyc + P_RL[k] + 1) % 8;
          due_v[k][s2] = 1'b1;
          due_c[k][s2] = w;
          due_d[k][s2] = m_mem[k][e_ma[k]];
        end
        if (P_MODE[k] == 0) m_ptr[k] = (w + 1) % P_N[k];
      end else begin
        e_we[k] = 1'b0;
        e_re[k] = 1'b0;
      end
    end
  endtask

  // Compare every DUT output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    model_cycle(0, {1'b0, grant_a}, {1'b0, rvalid_a}, rdata_a, maddr_a, mwe_a, mre_a, mwv_a);
    model_cycle(1, {2'b0, grant_b}, {2'b0, rvalid_b}, rdata_b, maddr_b, mwe_b, mre_b, mwv_b);
    model_cycle(2, grant_c, rvalid_c, rdata_c, maddr_c, mwe_c, mre_c, mwv_c);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          seq_c [4] = '{1, 0, 1, 0};
  logic [7:0]  seq_a [4] = '{8'h20, 8'h21, 8'h22, 8'h23};

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = '0; we[k] = '0; addr[k] = '0; wdata[k] = '0;
    end
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset mid-read: read granted to core 1, reset arrives the next cycle.
    req[0] = 4'b0010; we[0] = 4'b0000; addr[0] = 32'h0000_0500;
    #1 chk("t1 grant core1", 32'(grant_a), 32'h2);
    step();
    req[0] = 4'b0000;
    reset = 1'b1;
    #1;
    chk("t1 rst mem_read_en", 32'(mre_a), 32'h0);
    chk("t1 rst mem_addr", 32'(maddr_a), 32'h0);
    chk("t1 rst rvalid", 32'(rvalid_a), 32'h0);
    step();
    step();
    reset = 1'b0;
    req[0] = 4'b0101;
    #1 chk("t1 ptr0 grant core0", 32'(grant_a), 32'h1);
    step();
    chk("t1 no stale rvalid", 32'(rvalid_a), 32'h0);
    req[0] = 4'b0100;
    #1 chk("t1 grant core2", 32'(grant_a), 32'h4);
    step();
    req[0] = 4'b0000;
    step();

    // Single write then read by core 0.
    addr[0] = 32'h0000_0010; wdata[0] = 128'hDEADBEEF; we[0] = 4'b0001; req[0] = 4'b0001;
    #1 chk("t2 write grant", 32'(grant_a), 32'h1);
    step();
    chk("t2 mem_write_en", 32'(mwe_a), 32'h1);
    chk("t2 mem_addr", 32'(maddr_a), 32'h10);
    chk("t2 mem_write_val", mwv_a, 32'hDEADBEEF);
    we[0] = 4'b0000;
    #1 chk("t2 read grant", 32'(grant_a), 32'h1);
    step();
    chk("t2 write pulse ends", 32'(mwe_a), 32'h0);
    chk("t2 mem_read_en", 32'(mre_a), 32'h1);
    req[0] = 4'b0000;
    step();
    chk("t2 rvalid", 32'(rvalid_a), 32'h1);
    chk("t2 rdata", rdata_a, 32'hDEADBEEF);
    step();
    chk("t2 rvalid one cycle", 32'(rvalid_a), 32'h0);

    // Bring the pointer back to core 0 with a core 2 read.
    addr[0] = 32'h0010_1010;
    req[0] = 4'b0100;
    #1 chk("t3 pre grant core2", 32'(grant_a), 32'h4);
    step();
    req[0] = 4'b0000;
    step();
    step();

    // Round-robin with all three cores reading continuously.
    req[0] = 4'b0111;
    for (int t = 0; t < 6; t++) begin
      #1 chk($sformatf("t3 rr grant %0d", t), 32'(grant_a), 32'(1) << (t % 3));
      step();
      if (t >= 1) begin
        chk($sformatf("t3 rr rvalid %0d", t), 32'(rvalid_a), 32'(1) << ((t - 1) % 3));
        chk($sformatf("t3 rr rdata %0d", t), rdata_a, 32'hDEADBEEF);
      end
    end
    req[0] = 4'b0000;
    step();
    chk("t3 rr last rvalid", 32'(rvalid_a), 32'h4);

    // Fixed priority: core 0 always beats core 1.
    addr[1] = '0; we[1] = '0; req[1] = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      #1 chk($sformatf("t4 fixed grant %0d", t), 32'(grant_b), 32'h1);
      step();
    end
    req[1] = 4'b0010;
    #1 chk("t4 core1 same cycle", 32'(grant_b), 32'h2);
    step();
    req[1] = 4'b0000;
    step();
    step();

    // Pointer wrap on the 4-core instance, using writes that also seed test data.
    addr[2]  = {8'h21, 8'h20, 8'h23, 8'h22};
    wdata[2] = {32'd2, 32'd1, 32'd4, 32'd3};
    we[2]    = 4'b1111;
    req[2]   = 4'b0100;
    #1 chk("t5 grant core2", 32'(grant_c), 32'h4);
    step();
    req[2] = 4'b1001;
    #1 chk("t5 ptr3 grant core3", 32'(grant_c), 32'h8);
    step();
    req[2] = 4'b0001;
    #1 chk("t5 wrap grant core0", 32'(grant_c), 32'h1);
    step();
    req[2] = 4'b0010;
    #1 chk("t5 grant core1", 32'(grant_c), 32'h2);
    step();
    req[2] = 4'b0000;
    step();
    step();

    // Back-to-back reads with READ_LATENCY=3.
    we[2] = 4'b0000;
    for (int j = 0; j < 7; j++) begin
      if (j < 4) begin
        req[2] = 4'b1 << seq_c[j];
        addr[2][seq_c[j]*8 +: 8] = seq_a[j];
        #1 chk($sformatf("t6 grant %0d", j), 32'(grant_c), 32'(1) << seq_c[j]);
      end else begin
        req[2] = 4'b0000;
      end
      step();
      if (j >= 3) begin
        chk($sformatf("t6 rvalid %0d", j - 3), 32'(rvalid_c), 32'(1) << seq_c[j-3]);
        chk($sformatf("t6 rdata %0d", j - 3), rdata_c, 32'(j - 2));
      end
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory controller among NUM_CORES core memory ports.
- Used in the multi-core processor top, between the cores and the memory controller, on the same divided clock.
- Arbitrates one access per cycle, using round-robin or fixed priority.
- Registers the winning access onto the memory port and returns each read result to the core that issued it, with a tag.

Parameters:
- NUM_CORES, 2, number of requesting cores (1..8).
- MEM_WIDTH, 32, data width in bits.
- MEM_SIZE, 256, memory depth in words. Derived localparam ADDR_W = $clog2(MEM_SIZE).
- READ_LATENCY, 1, cycles from mem_read_en asserted on the memory port to mem_read_val valid (1..4).
- ARB_MODE, 0, arbitration mode. 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- core_req  in  NUM_CORES  per-core access request, held until granted.
- core_we  in  NUM_CORES  per-core access type: 1 = write, 0 = read.
- core_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*MEM_WIDTH  per-core write data, same packing.
- core_grant  out  NUM_CORES  one-hot or zero; combinational; request of core i accepted this cycle.
- core_rvalid  out  NUM_CORES  one-hot or zero; read data for core i is on core_rdata.
- core_rdata  out  MEM_WIDTH  read data, broadcast to all cores.
- mem_addr  out  ADDR_W  registered memory address.
- mem_write_en  out  1  registered write strobe.
- mem_read_en  out  1  registered read strobe.
- mem_write_val  out  MEM_WIDTH  registered write data.
- mem_read_val  in  MEM_WIDTH  memory read data.

Behaviour:
- Reset (async, active-high): state and outputs clear as listed below. Any in-flight reads are discarded and no core_rvalid is produced for them. Normal operation resumes on the first rising edge after reset deasserts.
  - mem_addr = 0, mem_write_en = 0, mem_read_en = 0, mem_write_val = 0.
  - core_rvalid = 0, core_rdata = 0.
  - Round-robin pointer = 0, so core 0 has highest priority.
  - Read tag pipeline cleared.
- Arbitration is combinational on core_req:
  - At most one core_grant bit per cycle.
  - core_grant = 0 when core_req = 0.
  - core_grant is never asserted for a core whose core_req is low.
- ARB_MODE=1 (fixed priority): the lowest-index requesting core wins.
- ARB_MODE=0 (round-robin):
  - Search starts at the pointer and proceeds upward with wrap-around modulo NUM_CORES; the first requester found wins.
  - On a grant to core k, the pointer becomes (k+1) mod NUM_CORES on the next edge.
  - With no grant, the pointer holds.
  - In mode 1 the pointer stays 0.
- Handshake: a core holds core_req, core_we, core_addr and core_wdata stable until the cycle in which its core_grant is high. The transfer occurs at that edge. The core may present a new request in the next cycle.
- Memory issue: at the edge following a grant to core k, the memory port registers take the following values and hold them for exactly one cycle:
  - mem_addr = core_addr[k].
  - mem_write_val = core_wdata[k].
  - mem_write_en = core_we[k].
  - mem_read_en = ~core_we[k].
- With no grant, mem_write_en = mem_read_en = 0. mem_addr and mem_write_val hold their previous values.
- Read return:
  - Each issued read pushes tag k into a READ_LATENCY-deep shift pipeline; a write or idle cycle pushes an invalid tag.
  - When a valid tag emerges (READ_LATENCY cycles after mem_read_en was high), the arbiter registers for one cycle core_rvalid[k] = 1 and core_rdata = mem_read_val, sampled at that edge.
  - Total grant-to-rvalid latency is READ_LATENCY+1 edges.
- Back-to-back: reads may be issued every cycle. Tags stay ordered, so returns occur in issue order, one per cycle, with no loss.
- Writes: core_rvalid is never asserted for a write.
- core_rdata holds its last value when core_rvalid = 0.
- NUM_CORES=1: the single core is granted whenever core_req is high.

Test Plan:
1. Reset mid-read: grant a read to core 1, then assert reset in the next cycle → core_rvalid stays 0 throughout, all mem_* outputs are 0, and the pointer is 0 after release.
2. Single write then read:
   - Core 0 writes addr 0x10, data 0xDEADBEEF.
   - Then core 0 reads addr 0x10 with READ_LATENCY=1.
   - Required: core_grant[0] in each request cycle; mem_write_en pulses one cycle with mem_addr = 0x10; core_rvalid[0] = 1 with core_rdata = 0xDEADBEEF exactly 2 edges after the read grant.
3. Round-robin, NUM_CORES=3, ARB_MODE=0: all cores hold reads continuously → grants go 0,1,2,0,1,2 on consecutive cycles; core_rvalid follows the same sequence delayed by READ_LATENCY+1.
4. Fixed priority, ARB_MODE=1: cores 0 and 1 both request continuously → core 0 is granted every cycle and core 1 is never granted; when core 0 drops its request, core 1 is granted in that same cycle.
5. Pointer wrap: NUM_CORES=4, pointer = 3; cores 0 and 3 request → core 3 is granted, the pointer wraps to 0, and core 0 is granted next.
6. READ_LATENCY=3: four back-to-back reads from cores 1,0,1,0 to addresses holding 1,2,3,4 → core_rvalid/core_rdata give (1,1),(0,2),(1,3),(0,4) on consecutive cycles, starting 4 edges after the first grant.
